// File: rtl/mip_pkg.sv
// mip_pkg
// Shared definitions for the frame-buffer scheduling slice.
// Holds the default frame geometry and the 3-bit scheduler state encoding.
// The controller and display logic decode the same encoding.
// No ports (package).

package mip_pkg;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 12;
   localparam int PIXELS = 307200;

   typedef enum logic [2:0] {
      CAPTURE = 3'd0,
      SYNC    = 3'd1,
      PROCESS = 3'd2,
      DRAIN   = 3'd3,
      HOLD    = 3'd4
   } sched_state_e;

endpackage

// File: rtl/mip_rd_pipe.sv
// mip_rd_pipe
// RD_LAT-deep shift register of {valid, addr}. It tracks every RAM read
// issued so that the address comes out in the same cycle as the RAM's read data.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   flush_i        : drops every read in flight (valid bits cleared)
//   in_valid_i     : a read is issued this cycle
//   in_addr_i      : address of that read
//   out_valid_o    : read data for out_addr_o is on the RAM bus this cycle
//   out_addr_o     : address belonging to the current RAM read data

module mip_rd_pipe #(
   parameter int ADDR_W = 19,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   input  logic [ADDR_W-1:0] in_addr_i,
   output logic              out_valid_o,
   output logic [ADDR_W-1:0] out_addr_o
);

   logic              valid_q [RD_LAT];
   logic [ADDR_W-1:0] addr_q  [RD_LAT];

   // A flush also kills the read entering this cycle. Nothing issued before
   // the abort may reach the core afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            valid_q[i] <= 1'b0;
            addr_q[i]  <= '0;
         end
      end else begin
         valid_q[0] <= in_valid_i && !flush_i;
         addr_q[0]  <= in_addr_i;
         for (int i = 1; i < RD_LAT; i++) begin
            valid_q[i] <= valid_q[i-1] && !flush_i;
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   assign out_valid_o = valid_q[RD_LAT-1];
   assign out_addr_o  = addr_q[RD_LAT-1];

endmodule

// File: rtl/mip_frame_scheduler.sv
// mip_frame_scheduler
// Sequences the shared camera frame-buffer RAM:
//   - CAPTURE passes camera writes through to the RAM.
//   - SYNC waits for a frame boundary.
//   - PROCESS sweeps all pixel addresses into the processor core.
//   - DRAIN waits for the remaining writebacks.
//   - HOLD freezes the processed frame for display.
// Optional feature: define FRAME_SCHED_DROP_CNT_EN to build the 16-bit
// saturating dropped-camera-pixel counter. Without it drop_cnt reads 0.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_start, cmd_live            : processing request / return-to-live pulses
//   pause_in                       : freezes camera writes during capture
//   cam_wr/addr/data/frame_start   : camera pixel stream (no backpressure)
//   proc_ready                     : core accepts a pixel this cycle
//   pix_valid/addr/data            : pixel stream to the core
//   wb_valid/addr/data, wb_ready   : processed pixel handshake from the core
//   ram_rd_en/addr, ram_rd_data    : RAM read port (RD_LAT cycle latency)
//   ram_wr_en/addr/data            : RAM write port
//   state, busy, done, drop_cnt    : status

module mip_frame_scheduler #(
   parameter int ADDR_W = mip_pkg::ADDR_W,
   parameter int DATA_W = mip_pkg::DATA_W,
   parameter int PIXELS = mip_pkg::PIXELS,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_start,
   input  logic              cmd_live,
   input  logic              pause_in,
   input  logic              cam_wr,
   input  logic [ADDR_W-1:0] cam_addr,
   input  logic [DATA_W-1:0] cam_data,
   input  logic              cam_frame_start,
   input  logic              proc_ready,
   output logic              pix_valid,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [DATA_W-1:0] pix_data,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic [2:0]        state,
   output logic              busy,
   output logic              done,
   output logic [15:0]       drop_cnt
);

   import mip_pkg::*;

   localparam int                CNT_W     = $clog2(PIXELS + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(PIXELS);

   sched_state_e      state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0]  wb_cnt_q;
   logic              done_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   logic              rd_en;
   logic              wb_ready_c;
   logic              cam_pass;
   logic              wb_fire;
   logic              pipe_valid;
   logic [ADDR_W-1:0] pipe_addr;

   // Next state plus which source owns the write port. Only one of
   // cam_pass / wb_ready_c can be set in any state, so the RAM write port
   // never has two drivers. cmd_live overrides everything, including a
   // cmd_start in the same cycle, and refuses a writeback that cycle.
   always_comb begin
      state_d    = state_q;
      rd_en      = 1'b0;
      wb_ready_c = 1'b0;
      cam_pass   = 1'b0;
      unique case (state_q)
         CAPTURE: begin
            cam_pass = cam_wr && !pause_in;
            if (cmd_start) state_d = SYNC;
         end
         SYNC: begin
            if (cam_frame_start) state_d = PROCESS;
            else                 cam_pass = cam_wr && !pause_in;
         end
         PROCESS: begin
            rd_en      = proc_ready;
            wb_ready_c = 1'b1;
            if (proc_ready && rd_ptr_q == LAST_ADDR) state_d = DRAIN;
         end
         DRAIN: begin
            wb_ready_c = 1'b1;
            if (wb_cnt_q == FULL_CNT) state_d = HOLD;
         end
         HOLD: begin
            if (cmd_start) state_d = SYNC;
         end
         default: state_d = CAPTURE;
      endcase
      if (cmd_live) begin
         state_d    = CAPTURE;
         wb_ready_c = 1'b0;
      end
   end

   assign wb_fire = wb_valid && wb_ready_c;

   // Counters only run inside a pass. They are cleared outside one so that
   // every pass restarts from address 0 with no writebacks counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CAPTURE;
         rd_ptr_q  <= '0;
         wb_cnt_q  <= '0;
         done_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == DRAIN) && (state_d == HOLD);

         if (cmd_live || state_q != PROCESS) rd_ptr_q <= '0;
         else if (rd_en && rd_ptr_q != LAST_ADDR) rd_ptr_q <= rd_ptr_q + 1'b1;

         if (cmd_live || !(state_q == PROCESS || state_q == DRAIN)) wb_cnt_q <= '0;
         else if (wb_fire) wb_cnt_q <= wb_cnt_q + 1'b1;

         wr_en_q <= cam_pass || wb_fire;
         if (cam_pass) begin
            wr_addr_q <= cam_addr;
            wr_data_q <= cam_data;
         end else if (wb_fire) begin
            wr_addr_q <= wb_addr;
            wr_data_q <= wb_data;
         end
      end
   end

`ifdef FRAME_SCHED_DROP_CNT_EN
   logic        drop_evt;
   logic [15:0] drop_cnt_q;

   // A camera pixel is lost when it arrives with the frame-start pulse that
   // begins a pass, or at any time while the sweep owns the RAM.
   assign drop_evt = cam_wr && ((state_q == SYNC && cam_frame_start) ||
                                state_q == PROCESS || state_q == DRAIN);

   always_ff @(posedge clk) begin
      if (rst) drop_cnt_q <= '0;
      else if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

   mip_rd_pipe #(
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (cmd_live),
      .in_valid_i  (rd_en),
      .in_addr_i   (rd_ptr_q),
      .out_valid_o (pipe_valid),
      .out_addr_o  (pipe_addr)
   );

   assign pix_valid   = pipe_valid;
   assign pix_addr    = pipe_valid ? pipe_addr : '0;
   assign pix_data    = pipe_valid ? ram_rd_data : '0;
   assign wb_ready    = wb_ready_c;
   assign ram_rd_en   = rd_en;
   assign ram_rd_addr = rd_ptr_q;
   assign ram_wr_en   = wr_en_q;
   assign ram_wr_addr = wr_addr_q;
   assign ram_wr_data = wr_data_q;
   assign state       = state_q;
   assign busy        = (state_q == SYNC) || (state_q == PROCESS) || (state_q == DRAIN);
   assign done        = done_q;

endmodule

// File: doc/mip_frame_scheduler.md
# mip_frame_scheduler

Owns the write and read sequencing of the shared camera frame-buffer RAM. It passes live camera writes through during capture. On command it waits for a frame boundary and blocks the camera. It then sweeps every pixel address through the processor core and writes the processed pixels back, and finally holds the processed frame for display. It sits between the camera capturer, the processor core and the dual-port frame RAM, under the keyboard controller.

## Interface
Parameters:
- ADDR_W, 19: RAM address width.
- DATA_W, 12: pixel width (RGB444).
- PIXELS, 307200: frame size (640x480); last address PIXELS-1.
- RD_LAT, 2: RAM read latency in clk cycles (1..4).

Ports:
- clk, in, 1: system clock; the only clock.
- rst, in, 1: reset, synchronous, active-high.
- cmd_start, in, 1: pulse; request a processing pass.
- cmd_live, in, 1: pulse; abort or leave, return to CAPTURE.
- pause_in, in, 1: gates camera writes while in CAPTURE.
- cam_wr, cam_addr[ADDR_W], cam_data[DATA_W], in: camera write strobe, address and data; no backpressure.
- cam_frame_start, in, 1: pulse coincident with the first pixel of a frame.
- proc_ready, in, 1: core can accept a pixel this cycle.
- pix_valid, pix_addr[ADDR_W], pix_data[DATA_W], out: pixel to the core.
- wb_valid, wb_addr[ADDR_W], wb_data[DATA_W], in: processed pixel from the core.
- wb_ready, out, 1: writeback accepted when wb_valid && wb_ready.
- ram_rd_en, ram_rd_addr[ADDR_W], out: RAM read port.
- ram_rd_data[DATA_W], in: RAM read data, RD_LAT cycles after ram_rd_en.
- ram_wr_en, ram_wr_addr[ADDR_W], ram_wr_data[DATA_W], out: RAM write port.
- state[3], busy, done, drop_cnt[16], out: status outputs.

## Operation
- States:
  - CAPTURE=0
  - SYNC=1
  - PROCESS=2
  - DRAIN=3
  - HOLD=4
- CAPTURE:
  - ram_wr_* = cam_* registered, when cam_wr && !pause_in.
  - cmd_start -> SYNC.
- SYNC:
  - Camera writes still pass through.
  - cam_frame_start -> PROCESS. The pixel arriving with that pulse is blocked and counted as a drop.
- PROCESS:
  - Camera writes are blocked; each cam_wr increments drop_cnt.
  - Read counter rd_ptr starts at 0.
  - Each cycle with proc_ready=1: ram_rd_en=1, ram_rd_addr=rd_ptr, then rd_ptr++.
  - After issuing PIXELS-1 -> DRAIN. rd_ptr does not wrap.
- DRAIN:
  - No reads are issued.
  - Wait until wb_cnt == PIXELS -> HOLD, with a done pulse of 1 cycle.
- PROCESS and DRAIN:
  - wb_ready=1.
  - Accepted writebacks drive ram_wr_* (registered) and increment wb_cnt.
- HOLD:
  - RAM writes disabled.
  - cmd_start -> SYNC (new pass on the held image is not allowed; the frame is re-captured).
- cmd_live in any state -> CAPTURE next cycle:
  - Counters cleared.
  - Reads still in flight are discarded: pix_valid suppressed.
  - wb_ready drops.
- Simultaneous cmd_live and cmd_start: cmd_live wins.
- busy=1 in SYNC, PROCESS and DRAIN.
- drop_cnt saturates at 16'hFFFF and clears only on rst.

## Timing
- Reset values:
  - state=CAPTURE
  - all *_en and *_valid = 0
  - addresses and data = 0
  - wb_ready=0, busy=0, done=0, drop_cnt=0
- Camera path latency is 1 cycle (cam_wr -> ram_wr_en).
- Writeback latency is 1 cycle (wb handshake -> ram_wr_en).
- pix_valid asserts exactly RD_LAT cycles after ram_rd_en.
  - pix_addr equals the issued address.
  - pix_data = ram_rd_data sampled that cycle.
- Throughput is 1 pixel per clk while proc_ready=1.
- wb_cnt reaching PIXELS on cycle N gives state=HOLD and done=1 on N+1.
- The write port is never driven by two sources: the camera and the writeback phases are mutually exclusive.

## Configuration
- FRAME_SCHED_DROP_CNT_EN defined: the 16-bit saturating drop counter is implemented.
- Not defined: drop_cnt is tied to 0 and no counter logic is generated.
- All other behaviour is identical with or without the macro.

## Structure
- Shared package mip_pkg holds:
  - ADDR_W, DATA_W, PIXELS.
  - The 3-bit state encoding constants (CAPTURE..HOLD), shared with the controller and display logic.
- Sub-module mip_rd_pipe: RD_LAT-deep shift register of {valid, addr} that aligns pix_addr with ram_rd_data. It has a flush input driven by cmd_live.

## Test plan
- Reset, then cam_wr addr 5 data 12'hABC in CAPTURE -> next cycle ram_wr_en=1, addr 5, data 12'hABC. With pause_in=1 -> no write.
- cmd_start, then cam_frame_start with cam_wr=1 -> state PROCESS, drop_cnt=1, ram_wr_en=0.
- PROCESS with proc_ready=1 constantly and RD_LAT=2 -> ram_rd_addr 0,1,2… every cycle. pix_valid first seen 2 cycles after the first ram_rd_en with pix_addr=0.
- proc_ready toggling 1010… -> reads on alternate cycles only. The last read is at address PIXELS-1, then DRAIN, with no address PIXELS issued.
- The core returns all PIXELS writebacks -> done pulses once, state=HOLD. Later cam_wr produces no RAM write.
- cmd_live mid-PROCESS with 2 reads in flight -> state CAPTURE next cycle, no pix_valid afterwards, wb_ready=0. drop_cnt is retained.
